keypad_scan_controller: RTL
===========================

KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven (dwell), range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000: consecutive stable cycles needed to accept a press or release, range 2..2^20-1.
REQ-003 SHALL have port clock_Value  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rowValue  input  4  keypad rows, active-low, asynchronous to clock_Value.
REQ-006 SHALL have port column  output  4  column drive, active-low one-cold.
REQ-007 SHALL have port keyCode  output  4  encoded key, equal to row_index*4 + col_index.
REQ-008 SHALL have port keyValid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 SHALL have port keyHeld  output  1  high from accepted press until accepted release.
REQ-010 SHALL have port scanActive  output  1  high only in state SCAN.

Function
REQ-011 SHALL pass rowValue through a 2-flop synchronizer; all row decisions use the synchronized value (rowSync).
REQ-012 SHALL implement states SCAN, DEBOUNCE, PRESSED, HELD, RELEASE.
REQ-013 SCAN: column SHALL hold each value for SCAN_DIV cycles, then rotate 1110 -> 0111 -> 1011 -> 1101 -> 1110.
REQ-014 Column index mapping SHALL be 1110=0, 1101=1, 1011=2, 0111=3. Row index is bit position, 0..3.
REQ-015 SCAN: on the last dwell cycle, if rowSync != 1111, SHALL freeze column, latch rowSync and column, and enter DEBOUNCE. Otherwise SHALL rotate.
REQ-016 If more than one row is low, the lowest-index low row SHALL be used for keyCode. The latched 4-bit row pattern is still the stability reference.
REQ-017 DEBOUNCE: SHALL count cycles while rowSync equals the latched pattern. On reaching DEBOUNCE_CNT, SHALL enter PRESSED.
REQ-018 DEBOUNCE: any mismatch SHALL clear the counter, return to SCAN, and advance to the next column. No keyValid is produced.
REQ-019 PRESSED: SHALL last exactly one cycle. keyCode SHALL update on entry. keyValid SHALL be 1 for that cycle only. SHALL then enter HELD.
REQ-020 keyCode SHALL keep its last value until the next accepted press.
REQ-021 HELD: column SHALL stay frozen. keyHeld SHALL be 1. On rowSync == 1111, SHALL enter RELEASE with the counter cleared.
REQ-022 RELEASE: SHALL count cycles of rowSync == 1111. On reaching DEBOUNCE_CNT, SHALL clear keyHeld, rotate to the next column, and enter SCAN with the dwell counter at 0.
REQ-023 RELEASE: any rowSync != 1111 SHALL return to HELD.
REQ-024 keyHeld SHALL stay 1 throughout RELEASE.
REQ-025 Presses on other keys while in HELD/RELEASE SHALL be ignored. At most one keyValid per press-release cycle.
REQ-026 The dwell counter and the debounce counter SHALL saturate, never wrap. Their widths SHALL be derived from the parameters.
REQ-027 Minimum press-to-keyValid latency SHALL be 2 (synchronizer) + remaining dwell + DEBOUNCE_CNT + 1 cycles.

Reset
REQ-028 Reset SHALL act asynchronously and take effect mid-operation in any state.
REQ-029 Reset values SHALL be: state SCAN, column 1110, keyCode 0000, keyValid 0, keyHeld 0, scanActive 1, counters 0, synchronizer flops 1111, latched row/column 1111/1110.
REQ-030 After reset deassertion, the first column rotation SHALL occur SCAN_DIV cycles later.

Structure
REQ-031 Shared package keypad_pkg SHALL hold the state enumeration, the four column constants, the ROWS_IDLE constant (1111), and default parameter values.
REQ-032 The synchronizer SHALL be sub-module keypad_row_sync (4-bit, 2-flop, async-reset to 1111).
REQ-033 The FSM, counters and encoder SHALL stay in the top module.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-034 Idle rows 1111 for 32 cycles after reset -> column sequence 1110,0111,1011,1101,1110, each held 4 cycles. keyValid never 1.
REQ-035 rowValue=1011 held while column=1101, released after 40 cycles -> one keyValid pulse with keyCode=9 (row 2, col 1). keyHeld high until 8 cycles after release, then scanning resumes at column 1110.
REQ-036 Bounce: row low for 3 cycles, then high, during DEBOUNCE -> return to SCAN, next column, no keyValid, keyCode unchanged.
REQ-037 rowValue=1010 on column 0111 -> keyCode=3 (row 0 wins). Exactly one keyValid.
REQ-038 Reset asserted mid-HELD -> outputs immediately at REQ-029 values. After deassertion, a fresh press is accepted normally.
REQ-039 Release bounce: rows return to 1111 for 5 cycles, then low again, then stay high for 8 cycles -> keyHeld drops once, no second keyValid.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and small encode helpers for the 4x4 keypad scanner.
// Column patterns are active-low one-cold; row patterns are active-low.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_HELD     = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    localparam logic [3:0] COL_0     = 4'b1110;
    localparam logic [3:0] COL_1     = 4'b1101;
    localparam logic [3:0] COL_2     = 4'b1011;
    localparam logic [3:0] COL_3     = 4'b0111;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    localparam int unsigned SCAN_DIV_DEFAULT     = 32'd1000;
    localparam int unsigned DEBOUNCE_CNT_DEFAULT = 32'd20000;

    // Scan order is 0 -> 3 -> 2 -> 1 -> 0 in column-index terms.
    function automatic logic [3:0] col_rotate(input logic [3:0] col);
        logic [3:0] nxt;
        case (col)
            COL_0:   nxt = COL_3;
            COL_3:   nxt = COL_2;
            COL_2:   nxt = COL_1;
            COL_1:   nxt = COL_0;
            default: nxt = COL_0;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            COL_0:   idx = 2'd0;
            COL_1:   idx = 2'd1;
            COL_2:   idx = 2'd2;
            COL_3:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-index low row wins when several rows are pulled low together.
    function automatic logic [1:0] low_row_index(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] key_encode(input logic [3:0] rows, input logic [3:0] col);
        return {low_row_index(rows), col_index(col)};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad rows into the clock domain.
// Both stages reset to the idle (all-high) row pattern.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] async_rows,
    output logic [3:0] sync_rows
);

    logic [3:0] meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r    <= ROWS_IDLE;
            sync_rows <= ROWS_IDLE;
        end else begin
            meta_r    <= async_rows;
            sync_rows <= meta_r;
        end
    end

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces presses and
// releases on the synchronized rows, and reports one encoded key per press.
module keypad_scan_controller
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
    input  logic       clock_Value,
    input  logic       reset,
    input  logic [3:0] rowValue,
    output logic [3:0] column,
    output logic [3:0] keyCode,
    output logic       keyValid,
    output logic       keyHeld,
    output logic       scanActive
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 32'd1);
    localparam logic [DW-1:0] DWELL_ZERO = {DW{1'b0}};
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 32'd1);
    localparam logic [CW-1:0] DEB_ZERO   = {CW{1'b0}};

    logic [3:0]    row_sync_s;
    state_t        state_r,   state_next_s;
    logic [DW-1:0] dwell_r,   dwell_next_s, dwell_inc_s;
    logic [CW-1:0] deb_r,     deb_next_s,   deb_inc_s;
    logic [3:0]    col_r,     col_next_s;
    logic [3:0]    lat_row_r, lat_row_next_s;
    logic [3:0]    lat_col_r, lat_col_next_s;
    logic [3:0]    code_r,    code_next_s;
    logic          valid_r,   valid_next_s;
    logic          held_r,    held_next_s;
    logic          scan_r,    scan_next_s;

    keypad_row_sync u_row_sync (
        .clk        (clock_Value),
        .rst        (reset),
        .async_rows (rowValue),
        .sync_rows  (row_sync_s)
    );

    // Both counters hold at their terminal count instead of wrapping.
    assign dwell_inc_s = (dwell_r == DWELL_LAST) ? dwell_r : dwell_r + DW'(1);
    assign deb_inc_s   = (deb_r == DEB_LAST) ? deb_r : deb_r + CW'(1);

    // Next-state and next-output logic for the scan/debounce/hold sequence.
    always_comb begin
        state_next_s   = state_r;
        dwell_next_s   = dwell_r;
        deb_next_s     = deb_r;
        col_next_s     = col_r;
        lat_row_next_s = lat_row_r;
        lat_col_next_s = lat_col_r;
        code_next_s    = code_r;
        case (state_r)
            ST_SCAN: begin
                if (dwell_r == DWELL_LAST) begin
                    dwell_next_s = DWELL_ZERO;
                    if (row_sync_s != ROWS_IDLE) begin
                        state_next_s   = ST_DEBOUNCE;
                        lat_row_next_s = row_sync_s;
                        lat_col_next_s = col_r;
                        deb_next_s     = DEB_ZERO;
                    end else begin
                        col_next_s = col_rotate(col_r);
                    end
                end else begin
                    dwell_next_s = dwell_inc_s;
                end
            end
            ST_DEBOUNCE: begin
                if (row_sync_s == lat_row_r) begin
                    if (deb_r == DEB_LAST) begin
                        state_next_s = ST_PRESSED;
                        code_next_s  = key_encode(lat_row_r, lat_col_r);
                        deb_next_s   = DEB_ZERO;
                    end else begin
                        deb_next_s = deb_inc_s;
                    end
                end else begin
                    state_next_s = ST_SCAN;
                    deb_next_s   = DEB_ZERO;
                    dwell_next_s = DWELL_ZERO;
                    col_next_s   = col_rotate(col_r);
                end
            end
            ST_PRESSED: begin
                state_next_s = ST_HELD;
            end
            ST_HELD: begin
                if (row_sync_s == ROWS_IDLE) begin
                    state_next_s = ST_RELEASE;
                    deb_next_s   = DEB_ZERO;
                end else begin
                    state_next_s = ST_HELD;
                end
            end
            ST_RELEASE: begin
                if (row_sync_s == ROWS_IDLE) begin
                    if (deb_r == DEB_LAST) begin
                        state_next_s = ST_SCAN;
                        deb_next_s   = DEB_ZERO;
                        dwell_next_s = DWELL_ZERO;
                        col_next_s   = col_rotate(col_r);
                    end else begin
                        deb_next_s = deb_inc_s;
                    end
                end else begin
                    state_next_s = ST_HELD;
                    deb_next_s   = DEB_ZERO;
                end
            end
            default: begin
                state_next_s = ST_SCAN;
                dwell_next_s = DWELL_ZERO;
                deb_next_s   = DEB_ZERO;
                col_next_s   = COL_0;
            end
        endcase
        valid_next_s = (state_next_s == ST_PRESSED);
        held_next_s  = (state_next_s == ST_PRESSED) || (state_next_s == ST_HELD) ||
                       (state_next_s == ST_RELEASE);
        scan_next_s  = (state_next_s == ST_SCAN);
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge clock_Value or posedge reset) begin
        if (reset) begin
            state_r   <= ST_SCAN;
            dwell_r   <= DWELL_ZERO;
            deb_r     <= DEB_ZERO;
            col_r     <= COL_0;
            lat_row_r <= ROWS_IDLE;
            lat_col_r <= COL_0;
            code_r    <= 4'b0000;
            valid_r   <= 1'b0;
            held_r    <= 1'b0;
            scan_r    <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            dwell_r   <= dwell_next_s;
            deb_r     <= deb_next_s;
            col_r     <= col_next_s;
            lat_row_r <= lat_row_next_s;
            lat_col_r <= lat_col_next_s;
            code_r    <= code_next_s;
            valid_r   <= valid_next_s;
            held_r    <= held_next_s;
            scan_r    <= scan_next_s;
        end
    end

    assign column     = col_r;
    assign keyCode    = code_r;
    assign keyValid   = valid_r;
    assign keyHeld    = held_r;
    assign scanActive = scan_r;

endmodule
